// File: rtl/score_display_pkg.sv
// Shared types and segment encodings for the score display block.
package score_display_pkg;

  typedef enum logic [1:0] {PLAY, FLASH, SHOW_HIGH} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Segment patterns {g,f,e,d,c,b,a} for digits 0..9, active-high
  localparam logic [0:9][6:0] SEG_TABLE = {
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

// File: rtl/score_display_bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder with optional zero blanking.
module bcd_to_7seg
  import score_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank_zero,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank_zero && digit == 4'd0) seg = SEG_BLANK;
    else if (digit <= 4'd9)          seg = SEG_TABLE[digit];
  end

endmodule

// File: rtl/score_display.sv
// Two-digit score display: live score during play, flashing final score
// at game over, then the high score supplied by the tracker.
module score_display
  import score_display_pkg::*;
#(
  parameter int BLINK_CYCLES = 6000000,
  parameter int HOLD_CYCLES  = 36000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd_ones,
  input  logic [3:0] bcd_tens,
  input  logic       isGameComplete,
  output logic [6:0] ss_ones,
  output logic [6:0] ss_tens,
  output logic       flashing
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int BW = $clog2(BLINK_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

  state_t        state, state_n;
  logic [HW-1:0] hold, hold_n;
  logic [BW-1:0] blink, blink_n;
  logic          phase, phase_n;
  logic [3:0]    shadow_ones, shadow_tens;
  logic [3:0]    disp_ones, disp_tens;
  logic          disp_blank;
  logic [6:0]    seg_ones, seg_tens;

  always_comb begin
    state_n    = state;
    hold_n     = hold;
    blink_n    = blink;
    phase_n    = phase;
    disp_ones  = bcd_ones;
    disp_tens  = bcd_tens;
    disp_blank = 1'b0;
    if (!isGameComplete) begin
      state_n = PLAY;
      hold_n  = '0;
      blink_n = '0;
      phase_n = 1'b1;
    end else begin
      case (state)
        PLAY: begin
          state_n = FLASH;
          hold_n  = '0;
          blink_n = '0;
          phase_n = 1'b1;
        end
        FLASH: begin
          if (hold == HOLD_MAX) begin
            state_n = SHOW_HIGH;
            hold_n  = '0;
            blink_n = '0;
            phase_n = 1'b1;
          end else begin
            hold_n = hold + 1'b1;
            if (blink == BLINK_MAX) begin
              blink_n = '0;
              phase_n = ~phase;
            end else begin
              blink_n = blink + 1'b1;
            end
          end
        end
        SHOW_HIGH: ;
        default: state_n = PLAY;
      endcase
    end
    // While flashing the tracker already shows the high score, so the
    // remembered in-game score is what gets displayed.
    if (state_n == FLASH) begin
      disp_ones  = shadow_ones;
      disp_tens  = shadow_tens;
      disp_blank = ~phase_n;
    end
  end

  bcd_to_7seg u_ones (.digit(disp_ones), .blank_zero(1'b0), .seg(seg_ones));
  bcd_to_7seg u_tens (.digit(disp_tens), .blank_zero(1'b1), .seg(seg_tens));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PLAY;
      hold        <= '0;
      blink       <= '0;
      phase       <= 1'b1;
      shadow_ones <= '0;
      shadow_tens <= '0;
      ss_ones     <= SEG_TABLE[0];
      ss_tens     <= SEG_BLANK;
      flashing    <= 1'b0;
    end else begin
      state    <= state_n;
      hold     <= hold_n;
      blink    <= blink_n;
      phase    <= phase_n;
      if (!isGameComplete) begin
        shadow_ones <= bcd_ones;
        shadow_tens <= bcd_tens;
      end
      ss_ones  <= disp_blank ? SEG_BLANK : seg_ones;
      ss_tens  <= disp_blank ? SEG_BLANK : seg_tens;
      flashing <= (state_n == FLASH);
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display with BLINK_CYCLES=4, HOLD_CYCLES=20.
module tb_score_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bcd_ones, bcd_tens;
  logic       isGameComplete;
  logic [6:0] ss_ones, ss_tens;
  logic       flashing;

  typedef struct {
    logic [6:0] tens;
    logic [6:0] ones;
    logic       flash;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  score_display #(.BLINK_CYCLES(4), .HOLD_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .bcd_ones(bcd_ones), .bcd_tens(bcd_tens),
    .isGameComplete(isGameComplete), .ss_ones(ss_ones), .ss_tens(ss_tens),
    .flashing(flashing)
  );

  // Monitor: the outputs settle after every edge; compare against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (ss_tens !== e.tens || ss_ones !== e.ones || flashing !== e.flash) begin
        n_bad++;
        $display("FAIL %s: got tens=%h ones=%h flash=%b, want tens=%h ones=%h flash=%b",
                 e.name, ss_tens, ss_ones, flashing, e.tens, e.ones, e.flash);
      end
    end
  end

  task automatic step(input logic r, input logic igc, input logic [3:0] t, input logic [3:0] o,
                      input logic [6:0] et, input logic [6:0] eo, input logic ef, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; isGameComplete = igc; bcd_tens = t; bcd_ones = o;
    e.tens = et; e.ones = eo; e.flash = ef; e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; isGameComplete = 1'b0; bcd_tens = 4'd0; bcd_ones = 4'd0;

    step(1, 0, 0, 0, 7'h00, 7'h3F, 0, "reset0");
    step(1, 0, 0, 0, 7'h00, 7'h3F, 0, "reset1");

    step(0, 0, 2, 4, 7'h5B, 7'h66, 0, "live_24");
    step(0, 0, 0, 7, 7'h00, 7'h07, 0, "live_07");

    // Game over: 2,3 in-game, tracker swaps to high score 4,5
    step(0, 0, 2, 3, 7'h5B, 7'h4F, 0, "ingame_23");
    for (int i = 0; i < 20; i++) begin
      if (((i / 4) % 2) == 0) step(0, 1, 4, 5, 7'h5B, 7'h4F, 1, $sformatf("flash_on_%0d", i));
      else                    step(0, 1, 4, 5, 7'h00, 7'h00, 1, $sformatf("flash_off_%0d", i));
    end
    for (int i = 0; i < 3; i++) step(0, 1, 4, 5, 7'h66, 7'h6D, 0, $sformatf("high_%0d", i));

    // Mid-flash restart at FLASH cycle 7
    step(0, 0, 1, 9, 7'h06, 7'h6F, 0, "ingame_19");
    for (int i = 0; i < 7; i++) begin
      if (i < 4) step(0, 1, 4, 5, 7'h06, 7'h6F, 1, $sformatf("flash2_on_%0d", i));
      else       step(0, 1, 4, 5, 7'h00, 7'h00, 1, $sformatf("flash2_off_%0d", i));
    end
    step(0, 0, 0, 1, 7'h00, 7'h06, 0, "restart_01");

    step(0, 0, 3, 12, 7'h4F, 7'h40, 0, "dash_ones");
    step(0, 0, 15, 0, 7'h40, 7'h3F, 0, "dash_tens");

    // Reset at FLASH cycle 10, then re-enter FLASH with a cleared shadow
    step(0, 0, 5, 6, 7'h6D, 7'h7D, 0, "ingame_56");
    for (int i = 0; i < 10; i++) begin
      if (((i / 4) % 2) == 0) step(0, 1, 4, 5, 7'h6D, 7'h7D, 1, $sformatf("flash3_on_%0d", i));
      else                    step(0, 1, 4, 5, 7'h00, 7'h00, 1, $sformatf("flash3_off_%0d", i));
    end
    step(1, 1, 4, 5, 7'h00, 7'h3F, 0, "reset_midflash");
    for (int i = 0; i < 5; i++) begin
      if (i < 4) step(0, 1, 4, 5, 7'h00, 7'h3F, 1, $sformatf("reflash_on_%0d", i));
      else       step(0, 1, 4, 5, 7'h00, 7'h00, 1, $sformatf("reflash_off_%0d", i));
    end
    step(0, 0, 9, 8, 7'h6F, 7'h7F, 0, "back_to_play");

    begin
      int budget;
      budget = 0;
      while (q.size() > 0 && budget < 10) begin
        @(posedge clk);
        budget++;
      end
      #2;
      if (q.size() > 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain: got %0d pending, want 0", q.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
